// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word PCs on a req/gnt/rvalid port and buffers the returned words in order for decode.
// Latency: first request one cycle after reset release; rvalid to instr_valid_o is one cycle (registered head, no bypass).
// Backpressure: new requests are credit-limited so buffered words plus granted-but-unreturned requests never exceed FIFO_DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // run_q holds off the first request until the first edge after reset release.
    logic          run_q;
    // pend_q: a request is being held ungranted; stale_q: that held request predates a redirect.
    logic          pend_q;
    logic          stale_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   stale_addr_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] out_q;
    logic [CW-1:0] discard_q;
    // slot_q[0] is the registered head shown to decode; later slots queue behind it.
    entry_t        slot_q [FIFO_DEPTH];

    logic          pop;
    logic          new_req;
    logic          granted;
    logic          drop;
    logic          push;
    logic          overflow;
    logic [CW:0]   used;
    logic [CW-1:0] out_next;
    logic [CW-1:0] count_next;
    logic [CW-1:0] discard_next;
    logic [CW-1:0] wr_idx;
    logic [31:0]   redirect_target;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // A held request keeps priority; a stale one keeps its pre-redirect address until granted.
    assign imem_req_o    = pend_q | new_req;
    assign imem_addr_o   = stale_q ? stale_addr_q : fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = slot_q[0].instr;
    assign pc_o          = slot_q[0].pc;

    // Credit, response filtering and next-state counter arithmetic.
    always_comb begin
        redirect_target = {redirect_pc_i[31:2], 2'b00};
        pop             = instr_valid_o & instr_ready_i;
        used            = {1'b0, count_q} + {1'b0, out_q} - {{CW{1'b0}}, pop};
        // No fresh request in a redirect cycle: it would fetch the old stream only to be discarded.
        new_req         = run_q & ~pend_q & ~redirect_i & (used < {1'b0, DEPTH_C});
        granted         = imem_req_o & imem_gnt_i;
        drop            = imem_rvalid_i & (discard_q != '0);
        push            = imem_rvalid_i & ~drop & ~redirect_i;
        out_next        = out_q + CW'(granted) - CW'(imem_rvalid_i);
        count_next      = redirect_i ? '0 : (count_q - CW'(pop) + CW'(push));
        // Every response still owed to the old stream is dropped, including a held request not yet granted.
        discard_next    = redirect_i ? (out_next + CW'(imem_req_o & ~imem_gnt_i))
                                     : (discard_q - CW'(drop));
        wr_idx          = count_q - CW'(pop);
        overflow        = imem_rvalid_i & (discard_q == '0) & ~redirect_i & (count_q == DEPTH_C) & ~pop;
    end

    // Fetch/response PCs, request hold state and the occupancy/outstanding/discard counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q        <= 1'b0;
            pend_q       <= 1'b0;
            stale_q      <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            stale_addr_q <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            count_q      <= '0;
            out_q        <= '0;
            discard_q    <= '0;
        end else begin
            run_q     <= 1'b1;
            pend_q    <= imem_req_o & ~imem_gnt_i;
            count_q   <= count_next;
            out_q     <= out_next;
            discard_q <= discard_next;

            if (redirect_i) begin
                stale_q      <= imem_req_o & ~imem_gnt_i;
                stale_addr_q <= imem_addr_o;
            end else if (granted) begin
                stale_q <= 1'b0;
            end

            // Granting a stale request must not advance the already-redirected fetch PC.
            if (redirect_i) begin
                fetch_pc_q <= redirect_target;
            end else if (granted && !stale_q) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end

            if (redirect_i) begin
                resp_pc_q <= redirect_target;
            end else if (push) begin
                resp_pc_q <= resp_pc_q + 32'd4;
            end
        end
    end

    // Shift-register buffer: pop shifts toward the head, push lands just behind the surviving entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            // With a single entry the head is left alone on pop so the outputs keep their last value.
            if (pop && (count_q > CW'(1))) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    slot_q[i] <= slot_q[i+1];
                end
            end
            if (push && (wr_idx < DEPTH_C)) begin
                slot_q[wr_idx[IW-1:0]] <= entry_t'{instr: imem_rdata_i, pc: resp_pc_q};
            end
        end
    end

    // Responses only answer granted requests, and the credit rule keeps a kept response from finding the buffer full.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(imem_rvalid_i && (out_q == '0)));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !overflow);
    // A raised request keeps its address until granted, redirect or not.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (imem_req_o && !imem_gnt_i) |=> (imem_req_o && $stable(imem_addr_o)));

endmodule
